multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM that sequences the MIPS datapath (PC, instruction/data memory, register file, ALU, muxes) over multiple cycles per instruction.
- Replaces the one-shot opcode decoder of the single-cycle build.
- Drives the datapath write enables and mux selects, and the 2-bit ALUOp consumed by the existing ALU-control decoder (funct → 3-bit ALU control).
- Also reports instruction retirement and illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instruction[31:26] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access complete; used only with MEM_WAIT_EN.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  write register: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU A input: 0 = PC, 1 = rs data.
- ALUSrcB  output  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  output  1  PCWrite | (PCWriteCond & zero).
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  output  1  one-cycle pulse when an unknown opcode is decoded.
- instr_count  output  CNT_W  retired-instruction count.
- state  output  4  current FSM state, for debug.

Behaviour:
- Moore FSM. The 4-bit state register updates only on the rising edge of clk. All control outputs decode combinationally from state (pc_en also uses zero).
- Reset: reset=1 at an edge gives state=FETCH and instr_count=0.
- While reset=1, the following are forced to 0 combinationally: PCWrite, PCWriteCond, pc_en, IRWrite, MemWrite, RegWrite, instr_done, illegal_op.
- Reset mid-instruction abandons the instruction without a register or memory write.
- Outputs not listed for a state are 0.
- FETCH(0): MemRead, IRWrite, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite. Next state DECODE.
- DECODE(1): ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0x23 lw / 0x2B sw → MEMADR
  - 0x00 R-type → EXEC
  - 0x04 beq → BRANCH
  - 0x02 j → JUMP
  - 0x08 addi → ADDIEX
  - any other opcode → FETCH, with illegal_op=1 and instr_done=1 this cycle.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD(3): MemRead, IorD=1. Next state MEMWB.
- MEMWB(4): RegWrite, MemtoReg=1, RegDst=0, instr_done. Next state FETCH.
- MEMWR(5): MemWrite, IorD=1, instr_done. Next state FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB(7): RegWrite, RegDst=1, MemtoReg=0, instr_done. Next state FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, instr_done. Next state FETCH.
- ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB(10): RegWrite, RegDst=0, MemtoReg=0, instr_done. Next state FETCH.
- JUMP(11): PCWrite, PCSource=10, instr_done. Next state FETCH.
- Codes 12–15 are unreachable. If ever entered, go to FETCH next cycle with all outputs 0.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- instr_count increments by 1 on every edge where instr_done=1, illegal ops included. It wraps from 2^CNT_W−1 to 0.

Optional Feature:
- MEM_WAIT_EN defined: FETCH, MEMRD and MEMWR hold state while mem_ready=0, with their strobes held asserted.
  - PCWrite and IRWrite in FETCH, and instr_done in MEMWR, assert only in the cycle where mem_ready=1.
  - The FSM advances on the edge where mem_ready=1.
- MEM_WAIT_EN undefined: mem_ready is ignored; every state lasts exactly one cycle.

Decomposition:
- Package mc_pkg holds:
  - state encodings (FETCH..JUMP)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - ALUSrcB and PCSource select codes.
- One sub-module, mc_output_decode: purely combinational state → control-vector map, including the reset gating.
- Next-state logic and the counter stay in the top module.

Test Plan:
- Hold reset 3 cycles, release → state=0; after reset, FETCH strobes MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01; instr_count=0; no write strobe while reset=1.
- Feed opcodes 0x23, 0x2B, 0x00, 0x08, 0x04, 0x02 in sequence → state traces 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-9-10, 0-1-8, 0-1-11; total 23 cycles; instr_count=6.
- beq with zero=1 vs zero=0 in BRANCH → pc_en=1 vs pc_en=0; PCSource=01 in both cases.
- opcode 0x3F → illegal_op and instr_done pulse in DECODE; next state 0; instr_count +1.
- Assert reset in MEMRD of a lw → RegWrite never asserts; state=0 the next cycle. Preload instr_count to all-ones via 2^32−1 retires (or a CNT_W=4 build: 15 retires) → next retire gives 0.
- With MEM_WAIT_EN and mem_ready low 3 cycles in FETCH → state stays 0, PCWrite=0 for 3 cycles; PCWrite pulses once when mem_ready=1, then DECODE.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, ALU and mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ASRCB_RT     = 2'b00;
  localparam logic [1:0] ASRCB_FOUR   = 2'b01;
  localparam logic [1:0] ASRCB_IMM    = 2'b10;
  localparam logic [1:0] ASRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic opcode_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the MIPS datapath (slave).
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             pc_en;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, pc_en, instr_done, illegal_op, instr_count, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, pc_en, instr_done, illegal_op, instr_count, state
  );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state -> control-vector map, with write/PC strobes masked during reset.
// MEM_WAIT_EN: FETCH and MEMWR completion strobes wait for mem_ready.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       reset,
  output ctrl_t      ctrl,
  output logic       pc_en
);

  logic ready;
`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
        ctrl.alu_src_b = ASRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      StDecode: begin
        ctrl.alu_src_b = ASRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
        if (!opcode_known(opcode)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      StMemAdr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = ready;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      StAluWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ASRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      StAddiWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StJump: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase

    // Reset abandons the instruction: no architectural side effects this cycle.
    if (reset) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.instr_done    = 1'b0;
      ctrl.illegal_op    = 1'b0;
    end
  end

  assign pc_en = ctrl.pc_write | (ctrl.pc_write_cond & zero);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM: next-state logic, state register and retire counter.
// MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until mem_ready.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_controller_if.master  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  ctrl_t            ctrl;
  logic             pc_en;
  logic             ready;

`ifdef MEM_WAIT_EN
  assign ready = bus.mem_ready;
`else
  assign ready = 1'b1;
`endif

  mc_output_decode u_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .reset     (reset),
    .ctrl      (ctrl),
    .pc_en     (pc_en)
  );

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = ready ? StDecode : StFetch;
      StDecode: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (bus.opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  state_d = ready ? StMemWb : StMemRd;
      StMemWr:  state_d = ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl.instr_done) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.pc_en       = pc_en;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.instr_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected state/controls/count vs DUT.
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [3:0]    st;
    logic [18:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [CW-1:0] count_m = '0;

  multicycle_controller_if #(.CNT_W(CW)) bus ();

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference control table: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  // RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,pc_en,instr_done,illegal_op}
  function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                           input logic z, input logic rst, input logic rdy);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill, w;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
`ifdef MEM_WAIT_EN
    w = rdy;
`else
    w = 1'b1;
`endif
    case (st)
      4'd0:  begin mrd = 1; irw = w; pcw = w; asb = 2'b01; end
      4'd1:  begin
        asb = 2'b11;
        if (!(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08})) begin ill = 1; done = 1; end
      end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mwr = 1; iord = 1; done = w; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; done = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: begin rw = 1; done = 1; end
      4'd11: begin pcw = 1; psrc = 2'b10; done = 1; end
      default: ;
    endcase
    if (rst) {pcw, pcwc, irw, mwr, rw, done, ill} = '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc,
            pcw | (pcwc & z), done, ill};
  endfunction

  // Drive one cycle of stimulus and push what the DUT must show during it.
  task automatic cycle(input logic [3:0] st, input logic [5:0] op, input logic z,
                       input logic rst, input logic rdy);
    exp_t e;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    reset         = rst;
    e.st  = st;
    e.ctl = exp_ctrl(st, op, z, rst, rdy);
    e.cnt = count_m;
    sb.push_back(e);
    if (rst) count_m = '0;
    else if (e.ctl[1]) count_m = count_m + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int abort_at);
    int tr[$];
    case (op)
      6'h23:   tr = '{0, 1, 2, 3, 4};
      6'h2B:   tr = '{0, 1, 2, 5};
      6'h00:   tr = '{0, 1, 6, 7};
      6'h08:   tr = '{0, 1, 9, 10};
      6'h04:   tr = '{0, 1, 8};
      6'h02:   tr = '{0, 1, 11};
      default: tr = '{0, 1};
    endcase
    foreach (tr[i]) begin
      cycle(4'(tr[i]), op, z, (i == abort_at), 1'b1);
      if (i == abort_at) break;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", 32'(bus.state), 32'(e.st));
      check("ctrl", 32'({bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                         bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                         bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.pc_en, bus.instr_done,
                         bus.illegal_op}), 32'(e.ctl));
      check("instr_count", 32'(bus.instr_count), 32'(e.cnt));
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    bus.opcode = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cycle(4'd0, 6'h00, 1'b0, 1'b1, 1'b1);
    cycle(4'd0, 6'h00, 1'b0, 1'b1, 1'b1);

    // lw, sw, R-type, addi, beq (not taken), j: 23 cycles, six retires
    run_instr(6'h23, 1'b0, -1);
    run_instr(6'h2B, 1'b0, -1);
    run_instr(6'h00, 1'b0, -1);
    run_instr(6'h08, 1'b0, -1);
    run_instr(6'h04, 1'b0, -1);
    run_instr(6'h02, 1'b0, -1);
    check("count_after_six", 32'(bus.instr_count), 32'd6);

    run_instr(6'h04, 1'b1, -1);
    run_instr(6'h3F, 1'b0, -1);
    check("count_after_illegal", 32'(bus.instr_count), 32'd8);

    // Reset during MEMRD of a lw, then a normal instruction from FETCH
    run_instr(6'h23, 1'b0, 3);
    run_instr(6'h00, 1'b0, -1);

`ifdef MEM_WAIT_EN
    for (int i = 0; i < 3; i++) cycle(4'd0, 6'h02, 1'b0, 1'b0, 1'b0);
    run_instr(6'h02, 1'b0, -1);
`endif

    guard = 0;
    while (count_m != '1 && guard < 40) begin
      run_instr(6'h02, 1'b0, -1);
      guard++;
    end
    check("count_max", 32'(bus.instr_count), 32'hF);
    run_instr(6'h02, 1'b0, -1);
    check("count_wrap", 32'(bus.instr_count), 32'h0);

    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
